// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// ParamRegisterFile
// ---------------------------------------------------------------------------
// General-purpose register bank that feeds the ALU operand muxes. Holds
// NUM_REGS registers of WIDTH bits. Every register whose write-select bit is
// set applies the same 3-bit FunSel operation to its own current value, so
// several registers can be incremented, loaded or cleared in one cycle with
// no interaction between them. Two combinational read ports return the
// current (pre-edge) contents. A registered overflow flag pulses for one
// cycle whenever an enabled increment or decrement wrapped (or clamped, when
// SATURATE is set).
//
// Parameters:
//   WIDTH     register width in bits, multiple of 8 and at least 16
//   NUM_REGS  number of registers, 2..16
//   SATURATE  0 = inc/dec wrap modulo 2^WIDTH, 1 = clamp at all-ones / zero
//   SEL_W     read-select width, derived from NUM_REGS
//
// Ports:
//   clock_i      rising-edge clock
//   resetN_i     synchronous active-low reset, clears all registers and ovf
//   dataIn_i     write data used by the load-style operations
//   regSel_i     write enable per register, any number of bits may be set
//   funSel_i     operation applied to every enabled register
//   outASel_i    read port A register index
//   outBSel_i    read port B register index
//   outA_o       contents of register outASel_i, zero when out of range
//   outB_o       contents of register outBSel_i, zero when out of range
//   ovf_o        one-cycle pulse after an enabled inc/dec wrap or clamp
// ---------------------------------------------------------------------------
module param_register_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4,
  parameter int SATURATE = 0,
  localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clock_i,
  input  logic                resetN_i,
  input  logic [WIDTH-1:0]    dataIn_i,
  input  logic [NUM_REGS-1:0] regSel_i,
  input  logic [2:0]          funSel_i,
  input  logic [SEL_W-1:0]    outASel_i,
  input  logic [SEL_W-1:0]    outBSel_i,
  output logic [WIDTH-1:0]    outA_o,
  output logic [WIDTH-1:0]    outB_o,
  output logic                ovf_o
);

  // Operation encoding shared with the single-register block.
  typedef enum logic [2:0] {
    FS_DEC       = 3'b000,
    FS_INC       = 3'b001,
    FS_LOAD      = 3'b010,
    FS_CLEAR     = 3'b011,
    FS_LOADLOW8  = 3'b100,
    FS_LOADLOW16 = 3'b101,
    FS_SHIFTBYTE = 3'b110,
    FS_SEXT16    = 3'b111
  } funSelE;

  // Catch illegal parameter combinations at elaboration instead of letting
  // the byte/half-word slices below silently go out of range.
  if ((WIDTH % 8) != 0 || WIDTH < 16) begin : gBadWidth
    $error("param_register_file: WIDTH must be a multiple of 8 and >= 16");
  end
  if (NUM_REGS < 2 || NUM_REGS > 16) begin : gBadNumRegs
    $error("param_register_file: NUM_REGS must be in 2..16");
  end

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             ovf_q;
  logic             ovf_d;
  funSelE           op;

  assign op = funSelE'(funSel_i);

  // Next-state for every register. Disabled registers hold; enabled ones
  // apply the selected operation to their own value only. The overflow
  // event is the OR of the wrap/clamp condition over all enabled
  // registers, and is zero whenever nothing is enabled or the operation is
  // not an increment/decrement.
  always_comb begin
    ovf_d = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (regSel_i[k]) begin
        unique case (op)
          FS_DEC: begin
            if (regs_q[k] == '0) begin
              ovf_d     = 1'b1;
              regs_d[k] = (SATURATE != 0) ? '0 : AllOnes;
            end else begin
              regs_d[k] = regs_q[k] - WIDTH'(1);
            end
          end
          FS_INC: begin
            if (regs_q[k] == AllOnes) begin
              ovf_d     = 1'b1;
              regs_d[k] = (SATURATE != 0) ? AllOnes : '0;
            end else begin
              regs_d[k] = regs_q[k] + WIDTH'(1);
            end
          end
          FS_LOAD:      regs_d[k] = dataIn_i;
          FS_CLEAR:     regs_d[k] = '0;
          FS_LOADLOW8:  regs_d[k] = {{(WIDTH-8){1'b0}}, dataIn_i[7:0]};
          FS_LOADLOW16: regs_d[k] = {{(WIDTH-16){1'b0}}, dataIn_i[15:0]};
          FS_SHIFTBYTE: regs_d[k] = {regs_q[k][WIDTH-9:0], dataIn_i[7:0]};
          FS_SEXT16:    regs_d[k] = {{(WIDTH-16){dataIn_i[15]}}, dataIn_i[15:0]};
          default:      regs_d[k] = regs_q[k];
        endcase
      end
    end
  end

  // State register. Reset is sampled on the clock edge and wins over any
  // write that happens to be requested in the same cycle.
  always_ff @(posedge clock_i) begin
    if (!resetN_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  // Read ports are plain muxes over the current state, so a read in the
  // same cycle as a write sees the old value. Selects that point past the
  // last register match no entry and fall through to zero.
  always_comb begin
    outA_o = '0;
    outB_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (outASel_i == SEL_W'(k)) begin
        outA_o = regs_q[k];
      end
      if (outBSel_i == SEL_W'(k)) begin
        outB_o = regs_q[k];
      end
    end
  end

  assign ovf_o = ovf_q;

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide.
- Every selected register applies the team's 3-bit FunSel operation set independently: decrement, increment, load, clear, and the partial/shift loads.
- Adds features a single register lacks:
  - one-hot multi-register write select
  - two combinational read ports
  - optional saturating arithmetic
  - a registered overflow/underflow flag
- Sits in the datapath as the general-purpose register block feeding the ALU operand muxes.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8 and >= 16.
- NUM_REGS, 4, number of registers; 2..16.
- SEL_W, $clog2(NUM_REGS), read-select width (derived, not overridden).
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones / zero.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset.
- I  input  WIDTH  write data.
- RegSel  input  NUM_REGS  one-hot-or-multi write enable; bit k enables register k.
- FunSel  input  3  operation applied to every enabled register.
- OutASel  input  SEL_W  read port A index.
- OutBSel  input  SEL_W  read port B index.
- OutA  output  WIDTH  R[OutASel], combinational from current state.
- OutB  output  WIDTH  R[OutBSel], combinational from current state.
- Ovf  output  1  registered; 1 for one cycle after any enabled inc wrapped/saturated or dec underflowed/saturated.

Behaviour:
- Reset: all state changes on the rising edge of Clock only; Reset is sampled on that edge (synchronous). When Reset==0 at a rising edge, all registers <= 0 and Ovf <= 0. Reset overrides RegSel/FunSel in that cycle, including mid-sequence.
- Write enables: registers with RegSel[k]==0 hold. Any number of RegSel bits may be set; each enabled register computes its own next value from its own current value (no cross-register interaction). RegSel==0 means no write, and Ovf <= 0.
- FunSel per enabled register Q (N = WIDTH), applied on the rising edge:
  - 000: Q <= Q-1.
  - 001: Q <= Q+1.
  - 010: Q <= I.
  - 011: Q <= 0.
  - 100: Q <= {0, I[7:0]} (zero-extend low byte).
  - 101: Q <= {0, I[15:0]} (zero-extend low half).
  - 110: Q <= {Q[N-9:0], I[7:0]} (shift left one byte, insert I[7:0]).
  - 111: Q <= sign-extend I[15:0] to N.
- Wrap (SATURATE=0): all-ones+1 -> 0; 0-1 -> all-ones. Either event sets Ovf for that register.
- Saturation (SATURATE=1): all-ones+1 holds all-ones; 0-1 holds 0. Either clamp sets Ovf.
- Ovf <= OR over enabled registers of the wrap/clamp condition for the current FunSel. It is 0 for FunSel 010..111 and deasserts the next cycle with no new event (single-cycle pulse, not sticky).
- Read ports:
  - Purely combinational; read-during-write returns the pre-edge value, and the new value appears after the edge (latency 1 cycle from write to read).
  - OutASel and OutBSel may be equal.
  - A select >= NUM_REGS returns 0.
- Latency: all writes take effect at the clock edge; Ovf is valid in the same cycle as the updated register value.
- No X propagation: every register and Ovf has a defined value after the first reset edge.

Test Plan (WIDTH=32, NUM_REGS=4 unless noted):
- Reset=0 for one edge after arbitrary state -> R0..R3 = 0, Ovf=0. Reset=0 with RegSel=4'b1111, FunSel=010, I=32'hDEADBEEF -> all still 0.
- R0=32'h00001234, RegSel=0001, FunSel=000, one edge -> OutA(sel 0)=32'h00001233. FunSel=001 twice -> 32'h00001235. RegSel=0 -> value holds, Ovf=0.
- Multi-write: R1=5, R2=32'hFFFFFFFF, RegSel=0110, FunSel=001 -> R1=6, R2=0, Ovf=1 for exactly one cycle. Next edge with FunSel=010 -> Ovf=0.
- SATURATE=1: R3=32'hFFFFFFFF, FunSel=001 -> R3 holds 32'hFFFFFFFF, Ovf=1. R3=0, FunSel=000 -> R3 holds 0, Ovf=1.
- Partial loads on R0=32'h11223344 with I=32'h0000ABCD:
  - FunSel=100 -> 32'h000000CD.
  - FunSel=101 -> 32'h0000ABCD.
  - FunSel=110 (from 32'h11223344) -> 32'h223344CD.
  - I=32'h00008001, FunSel=111 -> 32'hFFFF8001.
- Read-during-write: R2=7, OutASel=OutBSel=2, RegSel=0100, FunSel=010, I=9 -> both ports read 7 before the edge and 9 after. OutASel=3 with NUM_REGS=3 -> OutA=0.
